// File: rtl/weight_bpeb_loader.sv
// Weight BPEB loader: streams raw kernel weights into a shadow bank, BPEB-encodes each
// tap under the latched n_ap setting, and commits the bank to the array-facing
// registers only when the array grants a swap.
module weight_bpeb_loader #(
    parameter int num_pe_col       = 4,
    parameter int nb_taps          = 11,
    parameter int weight_width     = 16,
    parameter int weight_bpr_width = 24,
    parameter int ETC_width        = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic [3:0]                                   cfg_kernel_size,
    input  logic [3:0]                                   cfg_n_ap,
    input  logic                                         w_valid,
    input  logic [weight_width-1:0]                      w_data,
    output logic                                         w_ready,
    input  logic                                         swap_en,
    output logic                                         busy,
    output logic                                         load_done,
    output logic                                         cfg_err,
    output logic [num_pe_col*nb_taps*weight_width-1:0]     WRegs,
    output logic [num_pe_col*nb_taps*weight_bpr_width-1:0] WBPRs,
    output logic [num_pe_col*nb_taps*ETC_width-1:0]        WETCs
);

    localparam int CW = (num_pe_col > 1) ? $clog2(num_pe_col) : 1;
    localparam logic [3:0]    MAX_K    = 4'(nb_taps);
    localparam logic [CW-1:0] LAST_COL = CW'(num_pe_col - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StFlush, StWaitSwap} state_t;

    state_t                      state;
    logic [3:0]                  k_q;
    logic [3:0]                  n_q;
    logic [3:0]                  tap_cnt;
    logic [CW-1:0]               col_cnt;
    logic                        pipe_valid;
    logic [weight_width-1:0]     pipe_data;
    logic [CW-1:0]               pipe_col;
    logic [3:0]                  pipe_tap;

    logic [weight_width-1:0]     sh_w   [num_pe_col][nb_taps];
    logic [weight_bpr_width-1:0] sh_bpr [num_pe_col][nb_taps];
    logic [ETC_width-1:0]        sh_etc [num_pe_col][nb_taps];

    logic [weight_bpr_width-1:0] enc_bpr;
    logic [ETC_width-1:0]        enc_etc;

    // Low n groups are abandoned; each kept group g is {w[2g+1], w[2g], w[2g-1]}.
    function automatic logic [23:0] bpeb_enc(input logic [15:0] w, input logic [3:0] n);
        logic [16:0] wx;
        logic [23:0] r;
        wx = {w, 1'b0};
        r  = '0;
        for (int g = 0; g < 8; g++) begin
            if (g >= int'(n)) r[3*g +: 3] = wx[2*g +: 3];
        end
        return r;
    endfunction

    // Effective terms: groups that are neither all-zero nor all-one.
    function automatic logic [3:0] etc_count(input logic [23:0] b);
        logic [3:0] cnt;
        cnt = '0;
        for (int g = 0; g < 8; g++) begin
            if (b[3*g +: 3] != 3'b000 && b[3*g +: 3] != 3'b111) cnt = cnt + 4'd1;
        end
        return cnt;
    endfunction

    // Encoder for the registered pipeline beat.
    always_comb begin
        enc_bpr = bpeb_enc(pipe_data, n_q);
        enc_etc = etc_count(enc_bpr);
    end

    assign w_ready = (state == StLoad);

    // Control FSM, beat pipeline, shadow bank and committed outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            busy       <= 1'b0;
            load_done  <= 1'b0;
            cfg_err    <= 1'b0;
            k_q        <= '0;
            n_q        <= '0;
            tap_cnt    <= '0;
            col_cnt    <= '0;
            pipe_valid <= 1'b0;
            pipe_data  <= '0;
            pipe_col   <= '0;
            pipe_tap   <= '0;
            WRegs      <= '0;
            WBPRs      <= '0;
            WETCs      <= '0;
            for (int c = 0; c < num_pe_col; c++) begin
                for (int t = 0; t < nb_taps; t++) begin
                    sh_w[c][t]   <= '0;
                    sh_bpr[c][t] <= '0;
                    sh_etc[c][t] <= '0;
                end
            end
        end else begin
            load_done  <= 1'b0;
            cfg_err    <= 1'b0;
            pipe_valid <= 1'b0;

            // One-cycle-late write of the previously accepted beat.
            if (pipe_valid) begin
                sh_w[pipe_col][pipe_tap]   <= pipe_data;
                sh_bpr[pipe_col][pipe_tap] <= enc_bpr;
                sh_etc[pipe_col][pipe_tap] <= enc_etc;
            end

            unique case (state)
                StIdle: begin
                    if (start) begin
                        if (cfg_kernel_size == 4'd0 || cfg_kernel_size > MAX_K) begin
                            cfg_err <= 1'b1;
                        end else begin
                            k_q     <= cfg_kernel_size;
                            n_q     <= cfg_n_ap;
                            tap_cnt <= '0;
                            col_cnt <= '0;
                            busy    <= 1'b1;
                            state   <= StLoad;
                            // Unused taps must commit as zero, so wipe the whole bank.
                            for (int c = 0; c < num_pe_col; c++) begin
                                for (int t = 0; t < nb_taps; t++) begin
                                    sh_w[c][t]   <= '0;
                                    sh_bpr[c][t] <= '0;
                                    sh_etc[c][t] <= '0;
                                end
                            end
                        end
                    end
                end
                StLoad: begin
                    if (w_valid) begin
                        pipe_valid <= 1'b1;
                        pipe_data  <= w_data;
                        pipe_col   <= col_cnt;
                        pipe_tap   <= tap_cnt;
                        if (tap_cnt == k_q - 4'd1) begin
                            tap_cnt <= '0;
                            if (col_cnt == LAST_COL) state <= StFlush;
                            else                     col_cnt <= col_cnt + 1'b1;
                        end else begin
                            tap_cnt <= tap_cnt + 4'd1;
                        end
                    end
                end
                StFlush: begin
                    state <= StWaitSwap;
                end
                StWaitSwap: begin
                    if (swap_en) begin
                        for (int c = 0; c < num_pe_col; c++) begin
                            for (int t = 0; t < nb_taps; t++) begin
                                WRegs[(c*nb_taps+t)*weight_width +: weight_width]         <= sh_w[c][t];
                                WBPRs[(c*nb_taps+t)*weight_bpr_width +: weight_bpr_width] <= sh_bpr[c][t];
                                WETCs[(c*nb_taps+t)*ETC_width +: ETC_width]               <= sh_etc[c][t];
                            end
                        end
                        load_done <= 1'b1;
                        busy      <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_bpeb_loader.sv
// Self-checking bench for weight_bpeb_loader: random and directed kernel loads compared
// against a tap-level reference model of the committed weight/BPR/ETC vectors.
module tb_weight_bpeb_loader;

    localparam int NC = 4;
    localparam int NT = 11;
    localparam int WW = 16;
    localparam int BW = 24;
    localparam int EW = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [3:0]            cfg_kernel_size;
    logic [3:0]            cfg_n_ap;
    logic                  w_valid;
    logic [WW-1:0]         w_data;
    logic                  w_ready;
    logic                  swap_en;
    logic                  busy;
    logic                  load_done;
    logic                  cfg_err;
    logic [NC*NT*WW-1:0]   WRegs;
    logic [NC*NT*BW-1:0]   WBPRs;
    logic [NC*NT*EW-1:0]   WETCs;

    weight_bpeb_loader #(
        .num_pe_col       (NC),
        .nb_taps          (NT),
        .weight_width     (WW),
        .weight_bpr_width (BW),
        .ETC_width        (EW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .cfg_kernel_size (cfg_kernel_size),
        .cfg_n_ap        (cfg_n_ap),
        .w_valid         (w_valid),
        .w_data          (w_data),
        .w_ready         (w_ready),
        .swap_en         (swap_en),
        .busy            (busy),
        .load_done       (load_done),
        .cfg_err         (cfg_err),
        .WRegs           (WRegs),
        .WBPRs           (WBPRs),
        .WETCs           (WETCs)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int hs_cnt   = 0;

    // Reference model: committed and pending kernels as plain tap arrays.
    logic [15:0] cm_w [NC][NT];
    int          cm_n;
    logic [15:0] pd_w [NC][NT];
    int          pd_n;
    logic [15:0] beat_q [$];

    always @(negedge clk) begin
        if (load_done) done_cnt++;
        if (w_valid && w_ready) hs_cnt++;
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] ref_bpr(input logic [15:0] w, input int n);
        int wi;
        int bits;
        logic [23:0] r;
        wi = int'(w);
        r  = '0;
        for (int g = 0; g < 8; g++) begin
            if (g >= n) begin
                bits = ((wi >> (2*g+1)) & 1) * 4 + ((wi >> (2*g)) & 1) * 2;
                if (g > 0) bits = bits + ((wi >> (2*g-1)) & 1);
                r = r | (24'(bits) << (3*g));
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] ref_etc(input logic [23:0] b);
        int cnt;
        int grp;
        cnt = 0;
        for (int g = 0; g < 8; g++) begin
            grp = int'((b >> (3*g)) & 24'h7);
            if (grp != 0 && grp != 7) cnt++;
        end
        return 4'(cnt);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        logic [NT*WW-1:0] ew;
        logic [NT*BW-1:0] eb;
        logic [NT*EW-1:0] ee;
        for (int c = 0; c < NC; c++) begin
            for (int t = 0; t < NT; t++) begin
                ew[t*WW +: WW] = cm_w[c][t];
                eb[t*BW +: BW] = ref_bpr(cm_w[c][t], cm_n);
                ee[t*EW +: EW] = ref_etc(ref_bpr(cm_w[c][t], cm_n));
            end
            check($sformatf("%s wregs c%0d", tag, c), 512'(WRegs[c*NT*WW +: NT*WW]), 512'(ew));
            check($sformatf("%s wbprs c%0d", tag, c), 512'(WBPRs[c*NT*BW +: NT*BW]), 512'(eb));
            check($sformatf("%s wetcs c%0d", tag, c), 512'(WETCs[c*NT*EW +: NT*EW]), 512'(ee));
        end
    endtask

    task automatic clear_model();
        for (int c = 0; c < NC; c++)
            for (int t = 0; t < NT; t++) cm_w[c][t] = '0;
        cm_n = 0;
    endtask

    task automatic commit_model();
        for (int c = 0; c < NC; c++)
            for (int t = 0; t < NT; t++) cm_w[c][t] = pd_w[c][t];
        cm_n = pd_n;
    endtask

    task automatic wait_commit();
        int d0;
        int g;
        d0 = done_cnt;
        g  = 0;
        swap_en = 1'b1;
        while (!load_done && g < 10) begin
            tick();
            g++;
        end
        check("load_done seen", 512'(load_done), 512'(1));
        commit_model();
        check_outputs("commit");
        check("busy cleared", 512'(busy), 512'(0));
        swap_en = 1'b0;
        w_valid = 1'b0;
        tick();
        check("load_done pulse count", 512'(done_cnt - d0), 512'(1));
        check("load_done low after", 512'(load_done), 512'(0));
    endtask

    // vpct < 0 toggles w_valid every other cycle; keep_valid holds w_valid past the load.
    task automatic run_load(input int k, input int n, input int vpct, input bit do_swap,
                            input bit keep_valid);
        int beats;
        int guard;
        beats = 0;
        guard = 0;
        cfg_kernel_size = 4'(k);
        cfg_n_ap        = 4'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy after start", 512'(busy), 512'(1));
        for (int c = 0; c < NC; c++)
            for (int t = 0; t < NT; t++) pd_w[c][t] = '0;
        pd_n = n;
        while (beats < NC*k && guard < 4000) begin
            if (vpct < 0) w_valid = (guard % 2 == 0);
            else          w_valid = (int'($urandom_range(0, 99)) < vpct);
            if (beat_q.size() > 0) w_data = beat_q[0];
            else                   w_data = 16'($urandom);
            if (w_valid && w_ready) begin
                pd_w[beats / k][beats % k] = w_data;
                beats++;
                if (beat_q.size() > 0) void'(beat_q.pop_front());
            end
            tick();
            guard++;
        end
        check("beats accepted", 512'(beats), 512'(NC*k));
        w_valid = keep_valid;
        check("w_ready low after last beat", 512'(w_ready), 512'(0));
        if (do_swap) wait_commit();
    endtask

    initial begin
        int h0;
        int d0;
        rst = 1'b1;
        start = 1'b0;
        w_valid = 1'b0;
        w_data = '0;
        swap_en = 1'b0;
        cfg_kernel_size = '0;
        cfg_n_ap = '0;
        clear_model();
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state.
        check("reset busy", 512'(busy), 512'(0));
        check("reset w_ready", 512'(w_ready), 512'(0));
        check("reset load_done", 512'(load_done), 512'(0));
        check("reset cfg_err", 512'(cfg_err), 512'(0));
        check_outputs("reset");

        // K=3, N=0, {0, FFFF, 0} per column.
        for (int c = 0; c < NC; c++) begin
            beat_q.push_back(16'h0000);
            beat_q.push_back(16'hFFFF);
            beat_q.push_back(16'h0000);
        end
        run_load(3, 0, 100, 1'b1, 1'b0);
        check("k3 wreg c3 tap1", 512'(WRegs[(3*NT+1)*WW +: WW]), 512'(16'hFFFF));
        check("k3 wbpr c0 tap1", 512'(WBPRs[1*BW +: BW]), 512'(24'hFFFFFE));
        check("k3 wetc c2 tap1", 512'(WETCs[(2*NT+1)*EW +: EW]), 512'(4'd1));

        // K=1, w=1 with N=0 then N=1.
        repeat (NC) beat_q.push_back(16'h0001);
        run_load(1, 0, 100, 1'b1, 1'b0);
        check("n0 w1 bpr", 512'(WBPRs[0 +: BW]), 512'(24'h000002));
        check("n0 w1 etc", 512'(WETCs[0 +: EW]), 512'(4'd1));
        repeat (NC) beat_q.push_back(16'h0001);
        run_load(1, 1, 100, 1'b1, 1'b0);
        check("n1 w1 bpr", 512'(WBPRs[0 +: BW]), 512'(24'h0));
        check("n1 w1 etc", 512'(WETCs[0 +: EW]), 512'(4'd0));

        // K=2, 0x5555, toggling w_valid held past the load.
        repeat (2*NC) beat_q.push_back(16'h5555);
        h0 = hs_cnt;
        run_load(2, 0, -1, 1'b1, 1'b1);
        check("5555 handshakes", 512'(hs_cnt - h0), 512'(2*NC));
        check("5555 bpr", 512'(WBPRs[(NT+1)*BW +: BW]), 512'(24'h492492));
        check("5555 etc", 512'(WETCs[(NT+1)*EW +: EW]), 512'(4'd8));

        // Swap withheld for 10 cycles, then granted together with a start.
        run_load(3, int'($urandom_range(0, 7)), 70, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold busy", 512'(busy), 512'(1));
        end
        check_outputs("hold old kernel");
        d0 = done_cnt;
        swap_en = 1'b1;
        start = 1'b1;
        cfg_kernel_size = 4'd2;
        tick();
        swap_en = 1'b0;
        start = 1'b0;
        check("swap load_done", 512'(load_done), 512'(1));
        commit_model();
        check_outputs("swap commit");
        check("swap+start busy", 512'(busy), 512'(0));
        tick();
        check("swap+start ignored", 512'(w_ready), 512'(0));
        check("swap done count", 512'(done_cnt - d0), 512'(1));

        // Illegal kernel sizes.
        for (int i = 0; i < 2; i++) begin
            cfg_kernel_size = (i == 0) ? 4'd0 : 4'd12;
            start = 1'b1;
            tick();
            start = 1'b0;
            check($sformatf("cfg_err k%0d", cfg_kernel_size), 512'(cfg_err), 512'(1));
            check("cfg_err busy", 512'(busy), 512'(0));
            check("cfg_err w_ready", 512'(w_ready), 512'(0));
            tick();
            check("cfg_err one pulse", 512'(cfg_err), 512'(0));
            check("cfg_err still idle", 512'(w_ready), 512'(0));
        end

        // Reset in the middle of a load.
        d0 = done_cnt;
        cfg_kernel_size = 4'd4;
        cfg_n_ap = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        w_valid = 1'b1;
        w_data = 16'h1234;
        tick();
        w_data = 16'hBEEF;
        tick();
        w_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        check_outputs("mid reset");
        check("mid reset busy", 512'(busy), 512'(0));
        check("mid reset w_ready", 512'(w_ready), 512'(0));
        tick();
        check("mid reset no done", 512'(done_cnt - d0), 512'(0));
        run_load(4, 2, 80, 1'b1, 1'b0);

        // Random loads.
        for (int i = 0; i < 6; i++) begin
            run_load(int'($urandom_range(1, NT)), int'($urandom_range(0, 15)),
                     int'($urandom_range(30, 100)), 1'b1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
